mux2x1_rr_arbiter: RTL

- Round-robin arbiter that shares one 2:1 mux datapath between two valid/ready requesters.
- Registers the selected operand into a single-entry output slot.
- Drives the mux select `s` as the index of the last granted port.
- MAX_BURST bounds consecutive grants to one port while the other waits, so neither requester starves.

---
 rtl/mux2x1_rr_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mux2x1_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux between two valid/ready requesters,
// with a bounded burst per owner. Optional beat locking via MUX2X1_ARB_LOCK_EN.
module mux2x1_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    output logic             gnt1,
`ifdef MUX2X1_ARB_LOCK_EN
    input  logic             lock0,
    input  logic             lock1,
`endif
    output logic             s,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic             r_rr;
    logic             r_s;
    logic [WIDTH-1:0] r_y;
    logic             r_y_valid;

    logic             w_load;
    logic             w_under;
    logic             w_locked;
    logic             w_rr_vld;
    logic             w_rr_sel;
    logic             w_sel_vld;
    logic             w_sel;
    logic             w_same_owner;

`ifdef MUX2X1_ARB_LOCK_EN
    logic             r_lock;
    assign w_locked = r_lock;
`else
    assign w_locked = 1'b0;
`endif

    assign w_load       = !r_y_valid || y_ready;
    assign w_under      = (r_cnt < MAX_CNT);
    assign w_same_owner = (w_sel ? (r_state == ST_OWN1) : (r_state == ST_OWN0));

    // Round-robin / burst-limited choice of the next port
    always_comb begin
        w_rr_vld = 1'b0;
        w_rr_sel = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    w_rr_vld = 1'b1;
                    w_rr_sel = r_rr;
                end else if (req0 || req1) begin
                    w_rr_vld = 1'b1;
                    w_rr_sel = req1;
                end else begin
                    w_rr_vld = 1'b0;
                    w_rr_sel = 1'b0;
                end
            end
            ST_OWN0: begin
                if (req0 && (!req1 || w_under)) begin
                    w_rr_vld = 1'b1;
                    w_rr_sel = 1'b0;
                end else begin
                    w_rr_vld = req1;
                    w_rr_sel = req1;
                end
            end
            ST_OWN1: begin
                if (req1 && (!req0 || w_under)) begin
                    w_rr_vld = 1'b1;
                    w_rr_sel = 1'b1;
                end else begin
                    w_rr_vld = req0;
                    w_rr_sel = 1'b0;
                end
            end
            default: begin
                w_rr_vld = 1'b0;
                w_rr_sel = 1'b0;
            end
        endcase
    end

    // A held lock pins the owner and ignores the other port entirely
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel     = 1'b0;
        if (w_locked) begin
            w_sel     = (r_state == ST_OWN1);
            w_sel_vld = w_sel ? req1 : req0;
        end else begin
            w_sel     = w_rr_sel;
            w_sel_vld = w_rr_vld;
        end
    end

    assign gnt0 = rst_n && w_load && w_sel_vld && !w_sel;
    assign gnt1 = rst_n && w_load && w_sel_vld &&  w_sel;

    // Arbitration FSM and output slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_rr      <= 1'b0;
            r_s       <= 1'b0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
`ifdef MUX2X1_ARB_LOCK_EN
            r_lock    <= 1'b0;
`endif
        end else if (w_load) begin
            if (w_sel_vld) begin
                r_y       <= w_sel ? a1 : a0;
                r_y_valid <= 1'b1;
                r_s       <= w_sel;
                r_state   <= w_sel ? ST_OWN1 : ST_OWN0;
                r_rr      <= !w_sel;
                if (w_same_owner) begin
                    r_cnt <= w_under ? (r_cnt + 4'd1) : MAX_CNT;
                end else begin
                    r_cnt <= 4'd1;
                end
`ifdef MUX2X1_ARB_LOCK_EN
                r_lock    <= w_sel ? lock1 : lock0;
`endif
            end else begin
                r_y_valid <= 1'b0;
                if (!w_locked) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 4'd0;
                end else begin
                    r_state <= r_state;
                    r_cnt   <= r_cnt;
                end
            end
        end else begin
            r_y_valid <= r_y_valid;
        end
    end

    assign s       = r_s;
    assign y       = r_y;
    assign y_valid = r_y_valid;

endmodule
